// File: rtl/bc_operand_requester_if.sv
// Command, broadcast-buffer and FPU-operand handshakes of the lane-0 operand requester.
// master = the side that issues commands, feeds the buffer and accepts operands; slave = the requester.
interface bc_operand_requester_if #(
  parameter int MaxBlen   = 32,
  parameter int MaxPasses = 16,
  parameter int ELEN      = 64,
  parameter int BlenWidth = $clog2(MaxBlen + 1),
  parameter int PassWidth = $clog2(MaxPasses + 1)
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [BlenWidth-1:0] cmd_blen_i;
  logic [PassWidth-1:0] cmd_passes_i;
  logic                 bc_valid_i;
  logic [ELEN-1:0]      bc_data_i;
  logic                 bc_ready_o;
  logic                 bc_invalidate_o;
  logic                 opnd_valid_o;
  logic                 opnd_ready_i;
  logic [31:0]          opnd_data_o;
  logic [BlenWidth-1:0] opnd_idx_o;
  logic                 opnd_last_o;
  logic                 opnd_final_o;
  logic                 done_o;
  logic                 abort_i;
  logic [31:0]          stall_cycles_o;

  modport master (
    output cmd_valid_i, cmd_blen_i, cmd_passes_i, bc_valid_i, bc_data_i, opnd_ready_i, abort_i,
    input  cmd_ready_o, bc_ready_o, bc_invalidate_o, opnd_valid_o, opnd_data_o, opnd_idx_o,
           opnd_last_o, opnd_final_o, done_o, stall_cycles_o
  );

  modport slave (
    input  cmd_valid_i, cmd_blen_i, cmd_passes_i, bc_valid_i, bc_data_i, opnd_ready_i, abort_i,
    output cmd_ready_o, bc_ready_o, bc_invalidate_o, opnd_valid_o, opnd_data_o, opnd_idx_o,
           opnd_last_o, opnd_final_o, done_o, stall_cycles_o
  );
endinterface

// File: rtl/bc_operand_requester.sv
// Streams a re-readable broadcast buffer half to the lane FPU once per pass, then releases it.
// Optional stall counter enabled by defining BC_OPERAND_REQUESTER_PERF_EN.
module bc_operand_requester #(
  parameter int MaxBlen   = 32,
  parameter int MaxPasses = 16,
  parameter int BlenWidth = $clog2(MaxBlen + 1),
  parameter int PassWidth = $clog2(MaxPasses + 1)
) (
  input logic                   clk_i,
  input logic                   rst_i,
  bc_operand_requester_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STREAM, INVAL} state_e;

  localparam logic [BlenWidth-1:0] BlenOne = 1;
  localparam logic [PassWidth-1:0] PassOne = 1;

  state_e               state;
  logic [BlenWidth-1:0] blen;
  logic [BlenWidth-1:0] elem_cnt;
  logic [PassWidth-1:0] passes;
  logic [PassWidth-1:0] pass_cnt;
  logic                 cmd_ready;
  logic                 inval;
  logic                 streaming;
  logic                 bc_rdy;
  logic                 pop;
  logic                 elem_last;
  logic                 pass_last;
  logic                 unused_hi;

  logic                 vld_p0;
  logic [31:0]          data_p0;
  logic [BlenWidth-1:0] idx_p0;
  logic                 last_p0;
  logic                 final_p0;

  assign streaming = (state == STREAM);
  assign elem_last = (elem_cnt == blen - BlenOne);
  assign pass_last = (pass_cnt == passes - PassOne);
  // Pop only when the one-entry output stage is free or draining this cycle.
  assign bc_rdy    = streaming && (!vld_p0 || bus.opnd_ready_i) && !bus.abort_i;
  assign pop       = bus.bc_valid_i && bc_rdy;
  assign unused_hi = ^(bus.bc_data_i >> 32);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      inval     <= 1'b0;
      blen      <= '0;
      passes    <= '0;
      elem_cnt  <= '0;
      pass_cnt  <= '0;
    end else begin
      inval <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            blen      <= bus.cmd_blen_i;
            passes    <= bus.cmd_passes_i;
            elem_cnt  <= '0;
            pass_cnt  <= '0;
            cmd_ready <= 1'b0;
            // Empty commands still release the buffer half.
            if (bus.cmd_blen_i == '0 || bus.cmd_passes_i == '0) begin
              state <= INVAL;
              inval <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (bus.abort_i) begin
            state <= INVAL;
            inval <= 1'b1;
          end else if (pop) begin
            if (elem_last) begin
              elem_cnt <= '0;
              pass_cnt <= pass_cnt + PassOne;
              if (pass_last) begin
                state <= INVAL;
                inval <= 1'b1;
              end
            end else begin
              elem_cnt <= elem_cnt + BlenOne;
            end
          end
        end
        INVAL: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stage p0: operand register toward the FPU, drains independently of the FSM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      idx_p0   <= '0;
      last_p0  <= 1'b0;
      final_p0 <= 1'b0;
    end else if (streaming && bus.abort_i) begin
      vld_p0 <= 1'b0;
    end else if (pop) begin
      vld_p0   <= 1'b1;
      data_p0  <= bus.bc_data_i[31:0];
      idx_p0   <= elem_cnt;
      last_p0  <= elem_last;
      final_p0 <= elem_last && pass_last;
    end else if (bus.opnd_ready_i) begin
      vld_p0 <= 1'b0;
    end
  end

`ifdef BC_OPERAND_REQUESTER_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (state == IDLE && bus.cmd_valid_i) begin
      stall_cnt <= '0;
    end else if (streaming && !bus.bc_valid_i && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles_o = stall_cnt;
`else
  assign bus.stall_cycles_o = '0;
`endif

  assign bus.cmd_ready_o     = cmd_ready;
  assign bus.bc_ready_o      = bc_rdy;
  assign bus.bc_invalidate_o = inval;
  assign bus.done_o          = inval;
  assign bus.opnd_valid_o    = vld_p0;
  assign bus.opnd_data_o     = data_p0;
  assign bus.opnd_idx_o      = idx_p0;
  assign bus.opnd_last_o     = last_p0;
  assign bus.opnd_final_o    = final_p0;
endmodule

// File: doc/bc_operand_requester.md
Name: bc_operand_requester

Overview:
- Sits in lane 0 and is the consumer of the broadcast buffer's bc_valid/bc_ready/bc_data/bc_invalidate stream.
- Accepts one command per broadcast operand: element count per pass and number of passes. The buffer is re-readable, so the same data is streamed once per pass.
- Registers each fp32 element into a one-entry output stage that feeds the lane FPU operand port.
- Pulses bc_invalidate once after the final element of the final pass, releasing the current buffer half.

Parameters:
- MaxBlen, 32, maximum elements per pass; must match the broadcast buffer depth.
- MaxPasses, 16, maximum number of passes per command.
- BlenWidth, $clog2(MaxBlen+1), derived; width of the element count.
- PassWidth, $clog2(MaxPasses+1), derived; width of the pass count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted; high only in IDLE
- cmd_blen_i  in  BlenWidth  elements per pass, 0..MaxBlen
- cmd_passes_i  in  PassWidth  number of passes, 0..MaxPasses
- bc_valid_i  in  1  broadcast buffer has an element
- bc_data_i  in  ELEN  element data; fp32 in bits [31:0], bits [63:32] ignored
- bc_ready_o  out  1  element pop request to the buffer
- bc_invalidate_o  out  1  one-cycle pulse that flushes and swaps the buffer half
- opnd_valid_o  out  1  operand valid to the FPU
- opnd_ready_i  in  1  FPU accepts the operand
- opnd_data_o  out  32  fp32 operand
- opnd_idx_o  out  BlenWidth  element index within the pass
- opnd_last_o  out  1  last element of the current pass
- opnd_final_o  out  1  last element of the last pass
- done_o  out  1  one-cycle pulse, coincident with bc_invalidate_o
- abort_i  in  1  cancel the current command
- stall_cycles_o  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE; all counters 0; output stage empty. cmd_ready_o=1; bc_ready_o, bc_invalidate_o, opnd_valid_o, opnd_last_o, opnd_final_o, done_o = 0; opnd_data_o=0, opnd_idx_o=0, stall_cycles_o=0. Reset mid-command discards all state and issues no invalidate.
- FSM states: IDLE, STREAM, INVAL.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, latch blen and passes; clear elem_cnt and pass_cnt.
  - If blen==0 or passes==0, go to INVAL (the buffer half is still released). Otherwise go to STREAM.
- STREAM:
  - bc_ready_o = (!opnd_valid_o || opnd_ready_i) && !abort_i.
  - A transfer occurs when bc_valid_i && bc_ready_o. It loads opnd_data_o=bc_data_i[31:0], opnd_idx_o=elem_cnt, opnd_last_o=(elem_cnt==blen-1), opnd_final_o=last && (pass_cnt==passes-1), and sets opnd_valid_o on the next cycle. Latency is 1 cycle; throughput is 1 element per cycle.
  - elem_cnt wraps to 0 after blen-1, and pass_cnt increments at that point.
  - The final transfer moves the FSM to INVAL.
  - opnd_valid_o clears on opnd_ready_i unless a new transfer occurs in the same cycle.
  - With opnd_valid_o high and opnd_ready_i low, all operand outputs hold stable.
- INVAL:
  - bc_invalidate_o=1 and done_o=1 for exactly one cycle, then go to IDLE.
  - The output stage keeps draining independently. A pending final operand does not delay the invalidate.
  - The next command is not accepted until IDLE.
- abort_i:
  - In STREAM, go to INVAL the next cycle. The output stage is cleared (opnd_valid_o=0) and no further pops occur.
  - In IDLE, abort_i is ignored.
- The buffer presents valid data for every element of every pass. A bc_valid_i low in STREAM only stalls the block; it is not an error.
- Elements beyond blen are never popped within a pass.

Optional Feature:
- Macro: BC_OPERAND_REQUESTER_PERF_EN.
- Defined: stall_cycles_o increments on every STREAM cycle with bc_valid_i=0 and saturates at 2^32-1. It clears on reset and on command acceptance.
- Undefined: no counter is instantiated and stall_cycles_o is tied to 0.

Test Plan:
- blen=4, passes=1, bc_valid_i always 1, opnd_ready_i always 1 -> 4 consecutive operands with idx 0,1,2,3; last and final set on idx 3; bc_invalidate_o pulses the cycle after the 4th pop; cmd_ready_o high 2 cycles after that.
- blen=3, passes=2, data 0x3F800000/0x40000000/0x40400000 repeated -> 6 operands; opnd_last_o on idx 2 twice; opnd_final_o only on the 6th; exactly one invalidate.
- blen=4, opnd_ready_i low for 5 cycles after the first operand -> bc_ready_o=0 during that window; operand 0 held stable; no element lost or duplicated; total 4 operands.
- blen=0, passes=3 -> no bc_ready_o; invalidate and done pulse 1 cycle after command acceptance.
- blen=8, abort_i after the 3rd pop -> opnd_valid_o=0 next cycle; invalidate pulse; no further pops; new command accepted.
- PERF_EN defined, bc_valid_i low for 7 cycles mid-stream -> stall_cycles_o=7 at done; reads 0 when undefined.
